// File: rtl/cp_fetch_ctrl.sv
// cp_fetch_ctrl: single-outstanding instruction fetch FSM feeding a 2-entry {instr, pc} FIFO with redirect flush
module cp_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, tag, tag_n, target;
  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc [2];
  logic rd_ptr, wr_ptr, gnt, push, pop, redir;
  logic [1:0] count;
  assign target = redirect_pc_i & ~32'h3;
  assign redir = redirect_i && state != IDLE;
  assign imem_req_o = !rst_i && state == REQ && count != 2'd2;
  assign imem_addr_o = rst_i ? RESET_PC : pc;
  assign gnt = imem_req_o && imem_gnt_i;
  assign push = state == WAIT && imem_rvalid_i && !redirect_i;
  assign instr_valid_o = !rst_i && count != 2'd0 && !redirect_i;
  assign pop = instr_valid_o && instr_ready_i;
  assign instr_data_o = rst_i ? '0 : fifo_data[rd_ptr];
  assign instr_pc_o = rst_i ? '0 : fifo_pc[rd_ptr];
  always_comb begin
    state_n = state;
    pc_n = redir ? target : pc;
    tag_n = tag;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        state_n = gnt ? (redir ? FLUSH : WAIT) : REQ;
        tag_n = gnt && !redir ? pc : tag;
        pc_n = redir ? target : gnt ? pc + 32'd4 : pc;
      end
      WAIT: state_n = imem_rvalid_i ? REQ : redir ? FLUSH : WAIT;
      FLUSH: state_n = imem_rvalid_i ? REQ : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      pc <= RESET_PC;
      tag <= '0;
      count <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i] <= '0;
      end
    end else begin
      state <= state_n;
      pc <= pc_n;
      tag <= tag_n;
      if (redir) begin
        count <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (pop) rd_ptr <= ~rd_ptr;
        if (push) begin
          fifo_data[wr_ptr] <= imem_rdata_i;
          fifo_pc[wr_ptr] <= tag;
          wr_ptr <= ~wr_ptr;
        end
      end
    end
  end
endmodule

// File: doc/cp_fetch_ctrl.md
CP_FETCH_CTRL -- requirements
Module: cp_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_req_o, output, 1 bit: instruction memory request.
REQ-006 SHALL have port imem_addr_o, output, 32 bits: request address, word aligned.
REQ-007 SHALL have port imem_gnt_i, input, 1 bit: request accepted in this cycle.
REQ-008 SHALL have port imem_rvalid_i, input, 1 bit: read data valid.
REQ-009 SHALL have port imem_rdata_i, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port redirect_i, input, 1 bit: branch/jump/trap redirect.
REQ-011 SHALL have port redirect_pc_i, input, 32 bits: redirect target; bits [1:0] ignored and treated as 0.
REQ-012 SHALL have port instr_valid_o, output, 1 bit: instruction available to the decoder / instruction splitter.
REQ-013 SHALL have port instr_ready_i, input, 1 bit: decoder accepts the instruction.
REQ-014 SHALL have port instr_data_o, output, 32 bits: instruction word.
REQ-015 SHALL have port instr_pc_o, output, 32 bits: PC of instr_data_o.

Function
REQ-016 SHALL implement states IDLE, REQ, WAIT, FLUSH; at most one memory request outstanding.
REQ-017 SHALL hold fetched {instr, pc} pairs in a 2-entry FIFO with count 0..2; instr_data_o/instr_pc_o SHALL show the head entry.
REQ-018 IDLE SHALL last exactly one cycle after reset deassertion, then move to REQ; imem_rvalid_i SHALL be ignored in IDLE.
REQ-019 REQ SHALL drive imem_req_o=1, imem_addr_o=fetch pc, only while FIFO count<2; otherwise imem_req_o=0 and stay in REQ.
REQ-020 imem_req_o and imem_addr_o SHALL stay stable from assertion until imem_gnt_i, unless redirect_i withdraws the request (REQ-026).
REQ-021 REQ with imem_gnt_i=1 and no redirect: latch the request pc as tag, fetch pc += 4 (mod 2^32, wraps to 0), go to WAIT.
REQ-022 WAIT: imem_req_o=0; on imem_rvalid_i push {imem_rdata_i, tag} into the FIFO and go to REQ; next request is issued no earlier than the following cycle.
REQ-023 instr_valid_o SHALL equal (count!=0) AND NOT redirect_i; pop SHALL occur when instr_valid_o and instr_ready_i are both 1.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged and preserve order; the push SHALL never overflow, per REQ-019.
REQ-025 With instr_ready_i=0, the head entry and instr_valid_o SHALL remain stable.
REQ-026 redirect_i in any non-IDLE state: FIFO count set to 0; fetch pc set to {redirect_pc_i[31:2],2'b00}; a REQ request with imem_gnt_i=0 is withdrawn.
REQ-027 redirect_i in REQ with imem_gnt_i=1: go to FLUSH; the granted response SHALL be discarded.
REQ-028 redirect_i in WAIT: with imem_rvalid_i=1 the data SHALL be dropped and the state goes to REQ; without it the state goes to FLUSH.
REQ-029 FLUSH: imem_req_o=0; on imem_rvalid_i drop the data and go to REQ; redirect_i in FLUSH updates the fetch pc and stays in FLUSH.
REQ-030 After a redirect, the first imem_addr_o SHALL be the redirect target, and no pre-redirect instruction SHALL reach instr_valid_o.

Reset
REQ-031 rst_i=1 SHALL force on the next edge: state IDLE; fetch pc=RESET_PC; FIFO count=0 and entries 0.
REQ-032 While rst_i=1 and on the following edge: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_data_o=0, instr_pc_o=0.
REQ-033 Reset asserted in any state, including mid-request or mid-FLUSH, SHALL abandon all in-flight activity without output glitches after the reset edge.

Verification
REQ-034 Reset then gnt and rvalid 1 cycle after each req, ready=1, rdata=0x00000013 -> req addresses 0x0, 0x4, 0x8; instr_pc_o 0x0, 0x4, 0x8 in order.
REQ-035 instr_ready_i=0 for 10 cycles -> exactly two entries buffered; req held at 0 with imem_addr_o=0x8 not requested; releasing ready drains 0x0 then 0x4, then fetching resumes.
REQ-036 Redirect to 0x103 while in WAIT without rvalid -> FLUSH; the late rvalid data is dropped; next req addr=0x100; instr_pc_o next=0x100.
REQ-037 Redirect in the same cycle as imem_gnt_i at addr 0x8 -> response for 0x8 dropped; instr_valid_o=0 during the redirect cycle; next req addr=target.
REQ-038 Fetch pc 0xFFFFFFFC granted -> next req addr 0x00000000; rst_i pulsed in WAIT -> req=0 and instr_valid_o=0, then after one IDLE cycle req addr=RESET_PC.
